// File: rtl/ppe_ifmap_fetcher.sv
// ppe_ifmap_fetcher
//
// Fetches IFMAP rows for one PPE and buffers them for the MAC datapath.
// At timestep start the IFMAP memory pushes the first row on its own. The
// block then requests each further row, one request at a time, and stores
// the replies in a 2-entry FIFO. The FIFO head is offered to the PPE on a
// valid/ready stream.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready
// are both high. valid does not depend on ready. The payload is held stable
// while valid is high and ready is low.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             one-cycle pulse that begins a timestep
//   pkt_in_*          packets from the router: [32:29] dest, [28:25] opcode,
//                     [24:0] row bits
//   pkt_out_*         request packets to the IFMAP memory
//   row_*             head of the row FIFO: bits, absolute row index, and a
//                     flag for the final row of the timestep
//   done              all rows delivered; held until the next start or reset
//   drop_err          one-cycle pulse after a misaddressed packet is dropped
module ppe_ifmap_fetcher #(
    parameter int PE_ID        = 5,
    parameter int IMEM_ID      = 11,
    parameter int IFMAP_SIZE   = 25,
    parameter int OUTPUT_SIZE  = 21,
    parameter int OP_PPE_INPUT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pkt_in_valid,
    output logic                  pkt_in_ready,
    input  logic [IFMAP_SIZE+7:0] pkt_in_data,
    output logic                  pkt_out_valid,
    input  logic                  pkt_out_ready,
    output logic [IFMAP_SIZE+7:0] pkt_out_data,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [IFMAP_SIZE-1:0] row_data,
    output logic [4:0]            row_idx,
    output logic                  row_last,
    output logic                  done,
    output logic                  drop_err
);

    localparam logic [3:0] MY_ID    = 4'(PE_ID);
    localparam logic [3:0] MEM_ID   = 4'(IMEM_ID);
    localparam logic [3:0] OP_ROW   = 4'(OP_PPE_INPUT);
    localparam logic [4:0] BASE     = 5'(PE_ID - 5);
    localparam logic [4:0] LAST_IDX = 5'(PE_ID - 5 + OUTPUT_SIZE - 1);
    localparam logic [4:0] N_ROWS   = 5'(OUTPUT_SIZE);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FIRST = 3'd1,
        S_ISSUE      = 3'd2,
        S_REQ        = 3'd3,
        S_WAIT_RESP  = 3'd4,
        S_DRAIN      = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            rx_count_q, rx_count_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  drop_err_q, drop_err_d;
    logic [IFMAP_SIZE-1:0] mem_data_q [2];
    logic [IFMAP_SIZE-1:0] mem_data_d [2];
    logic [4:0]            mem_idx_q  [2];
    logic [4:0]            mem_idx_d  [2];

    logic       in_fire;
    logic       pkt_ok;
    logic       push;
    logic       pop;
    logic [4:0] next_idx;
    logic [1:0] occ_after_pop;

    // Index of the row the next accepted reply belongs to; it also names the
    // row to request while in S_REQ, since rx_count is frozen there.
    assign next_idx = BASE + rx_count_q;

    assign pkt_in_ready  = (state_q == S_WAIT_FIRST) || (state_q == S_WAIT_RESP);
    assign in_fire       = pkt_in_valid && pkt_in_ready;
    assign pkt_ok        = (pkt_in_data[IFMAP_SIZE+7 -: 4] == MY_ID) &&
                           (pkt_in_data[IFMAP_SIZE+3 -: 4] == OP_ROW);
    assign push          = in_fire && pkt_ok;
    assign pop           = row_valid && row_ready;
    assign occ_after_pop = count_q - {1'b0, pop};

    // FIFO bookkeeping. A reply is only requested when a slot is free, so a
    // push into a full FIFO cannot occur.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_idx_d  = mem_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = pkt_in_data[IFMAP_SIZE-1:0];
            mem_idx_d[wr_ptr_q]  = next_idx;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Next-state logic for the request sequencer.
    always_comb begin
        state_d    = state_q;
        rx_count_d = rx_count_q;
        drop_err_d = in_fire && !pkt_ok;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_WAIT_FIRST;
                    rx_count_d = '0;
                end
            end
            S_WAIT_FIRST, S_WAIT_RESP: begin
                if (push) begin
                    rx_count_d = rx_count_q + 5'd1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rx_count_q == N_ROWS) begin
                    state_d = S_DRAIN;
                end else if (occ_after_pop <= 2'd1) begin
                    // A slot is guaranteed for the reply we are about to ask for.
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pkt_out_ready) begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rx_count_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_count_q <= rx_count_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Storage needs no reset: every read of it is gated by row_valid.
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_idx_q  <= mem_idx_d;
    end

    assign pkt_out_valid = (state_q == S_REQ);
    assign pkt_out_data  = pkt_out_valid ?
                           {MEM_ID, MY_ID, {(IFMAP_SIZE-5){1'b0}}, next_idx} : '0;

    assign row_valid = (count_q != 2'd0);
    assign row_data  = row_valid ? mem_data_q[rd_ptr_q] : '0;
    assign row_idx   = row_valid ? mem_idx_q[rd_ptr_q] : '0;
    assign row_last  = row_valid && (mem_idx_q[rd_ptr_q] == LAST_IDX);
    assign done      = (state_q == S_DONE);
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_ppe_ifmap_fetcher.sv
module tb_ppe_ifmap_fetcher;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // PE_ID = 5 instance
  logic        start = 1'b0;
  logic        pkt_in_valid = 1'b0;
  logic        pkt_in_ready;
  logic [32:0] pkt_in_data = '0;
  logic        pkt_out_valid;
  logic        pkt_out_ready = 1'b1;
  logic [32:0] pkt_out_data;
  logic        row_valid;
  logic        row_ready = 1'b1;
  logic [24:0] row_data;
  logic [4:0]  row_idx;
  logic        row_last;
  logic        done;
  logic        drop_err;

  // PE_ID = 9 instance
  logic        s9_start = 1'b0;
  logic        s9_in_valid = 1'b0;
  logic        s9_in_ready;
  logic [32:0] s9_in_data = '0;
  logic        s9_out_valid;
  logic        s9_out_ready = 1'b1;
  logic [32:0] s9_out_data;
  logic        s9_row_valid;
  logic        s9_row_ready = 1'b0;
  logic [24:0] s9_row_data;
  logic [4:0]  s9_row_idx;
  logic        s9_row_last;
  logic        s9_done;
  logic        s9_drop_err;

  int n_checks = 0;
  int n_fail = 0;

  ppe_ifmap_fetcher #(.PE_ID(5)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready), .pkt_in_data(pkt_in_data),
    .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready), .pkt_out_data(pkt_out_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last), .done(done), .drop_err(drop_err)
  );

  ppe_ifmap_fetcher #(.PE_ID(9)) u_dut9 (
    .clk(clk), .reset(reset), .start(s9_start),
    .pkt_in_valid(s9_in_valid), .pkt_in_ready(s9_in_ready), .pkt_in_data(s9_in_data),
    .pkt_out_valid(s9_out_valid), .pkt_out_ready(s9_out_ready), .pkt_out_data(s9_out_data),
    .row_valid(s9_row_valid), .row_ready(s9_row_ready), .row_data(s9_row_data),
    .row_idx(s9_row_idx), .row_last(s9_row_last), .done(s9_done), .drop_err(s9_drop_err)
  );

  // ---------------- expected-value helpers ----------------
  function automatic logic [24:0] row_pat(input logic [4:0] i);
    return {5{i}};
  endfunction

  function automatic logic [32:0] req_pkt(input logic [3:0] pe, input logic [4:0] idx);
    return {4'd11, pe, 20'd0, idx};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs are driven and outputs sampled at negedge; all DUT outputs are
  // state-decoded, so a handshake seen here completes at the next posedge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; pkt_in_valid = 1'b0; s9_start = 1'b0; s9_in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] dst, input logic [3:0] op,
                          input logic [24:0] dat, output bit acc);
    acc = 1'b0;
    @(negedge clk);
    pkt_in_valid = 1'b1;
    pkt_in_data  = {dst, op, dat};
    for (int i = 0; i < 20 && !acc; i++) begin
      if (pkt_in_ready) acc = 1'b1;
      @(negedge clk);
    end
    pkt_in_valid = 1'b0;
  endtask

  task automatic wait_req(output bit got, output logic [32:0] d);
    got = 1'b0;
    d = '0;
    pkt_out_ready = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (pkt_out_valid) begin got = 1'b1; d = pkt_out_data; end
    end
  endtask

  // Full timestep on the PE_ID=5 instance: memory answers each request at
  // once, PPE consumes every row immediately.
  task automatic run_timestep();
    int pops, reqs, cyc;
    bit rep_pend;
    logic [4:0] rep_idx, exp_idx;
    pops = 0; reqs = 0; cyc = 0; rep_pend = 1'b1; rep_idx = 5'd0; exp_idx = 5'd0;
    row_ready = 1'b1; pkt_out_ready = 1'b1;
    pulse_start();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_after_start: got %b want 0", done); end
    while (pops < 21 && cyc < 400) begin
      if (rep_pend) begin
        pkt_in_valid = 1'b1;
        pkt_in_data  = {4'd5, 4'd1, row_pat(rep_idx)};
      end else begin
        pkt_in_valid = 1'b0;
      end
      if (rep_pend && pkt_in_ready) rep_pend = 1'b0;
      if (pkt_out_valid) begin
        n_checks++;
        if (pkt_out_data !== req_pkt(4'd5, 5'(reqs + 1))) begin
          n_fail++; $display("FAIL req_%0d: got %h want %h", reqs + 1, pkt_out_data, req_pkt(4'd5, 5'(reqs + 1)));
        end
        rep_idx = 5'(reqs + 1);
        reqs++;
        rep_pend = 1'b1;
      end
      if (row_valid) begin
        n_checks++;
        if (row_idx !== exp_idx || row_data !== row_pat(exp_idx) || row_last !== (exp_idx == 5'd20)) begin
          n_fail++; $display("FAIL row_%0d: got idx %0d data %h last %b", exp_idx, row_idx, row_data, row_last);
        end
        exp_idx++;
        pops++;
      end
      @(negedge clk);
      cyc++;
    end
    pkt_in_valid = 1'b0;
    n_checks++; if (pops != 21) begin n_fail++; $display("FAIL row_count: got %0d want 21", pops); end
    n_checks++; if (reqs != 20) begin n_fail++; $display("FAIL req_count: got %0d want 20", reqs); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b want 0", done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_after_drain: got %b want 1", done); end
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL empty_at_done: got %b want 0", row_valid); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (pkt_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", pkt_in_ready); end
    n_checks++; if (pkt_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", pkt_out_valid); end
    n_checks++; if (pkt_out_data !== 33'd0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", pkt_out_data); end
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL rst_row_valid: got %b want 0", row_valid); end
    n_checks++; if (row_data !== 25'd0) begin n_fail++; $display("FAIL rst_row_data: got %h want 0", row_data); end
    n_checks++; if (row_idx !== 5'd0) begin n_fail++; $display("FAIL rst_row_idx: got %0d want 0", row_idx); end
    n_checks++; if (row_last !== 1'b0) begin n_fail++; $display("FAIL rst_row_last: got %b want 0", row_last); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL rst_drop_err: got %b want 0", drop_err); end
    n_checks++; if ({s9_in_ready, s9_out_valid, s9_row_valid, s9_done} !== 4'b0) begin
      n_fail++; $display("FAIL rst_pe9_ctrl: got %b want 0000", {s9_in_ready, s9_out_valid, s9_row_valid, s9_done});
    end
  endtask

  task automatic test_two_timesteps();
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_held: got %b want 1", done); end
    end
    run_timestep();
  endtask

  task automatic test_req_stall();
    bit got;
    row_ready = 1'b1; pkt_out_ready = 1'b0;
    pulse_start();
    pkt_in_valid = 1'b1; pkt_in_data = {4'd5, 4'd1, row_pat(5'd0)};
    @(negedge clk);
    pkt_in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pkt_out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL stall_req_seen: got %b want 1", got); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (pkt_out_valid !== 1'b1 || pkt_out_data !== req_pkt(4'd5, 5'd1)) begin
        n_fail++; $display("FAIL stall_hold_%0d: got v=%b d=%h want v=1 d=%h", i, pkt_out_valid, pkt_out_data, req_pkt(4'd5, 5'd1));
      end
      @(negedge clk);
    end
    pkt_out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (pkt_out_valid !== 1'b0 || pkt_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stall_no_dup_%0d: got v=%b rdy=%b want v=0 rdy=1", i, pkt_out_valid, pkt_in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bad_packets();
    bit acc;
    row_ready = 1'b0;
    send_pkt(4'd6, 4'd1, row_pat(5'd1), acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bad_dest_acc: got %b want 1", acc); end
    n_checks++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL bad_dest_drop: got %b want 1", drop_err); end
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL bad_dest_store: got %b want 0", row_valid); end
    send_pkt(4'd5, 4'd3, row_pat(5'd1), acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bad_op_acc: got %b want 1", acc); end
    n_checks++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL bad_op_drop: got %b want 1", drop_err); end
    n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL bad_op_store: got %b want 0", row_valid); end
    @(negedge clk);
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_width: got %b want 0", drop_err); end
    n_checks++; if (pkt_in_ready !== 1'b1) begin n_fail++; $display("FAIL still_waiting: got %b want 1", pkt_in_ready); end
    send_pkt(4'd5, 4'd1, row_pat(5'd1), acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL good_acc: got %b want 1", acc); end
    n_checks++;
    if (row_valid !== 1'b1 || row_idx !== 5'd1 || row_data !== row_pat(5'd1) || drop_err !== 1'b0) begin
      n_fail++; $display("FAIL good_store: got v=%b idx=%0d d=%h drop=%b want v=1 idx=1 d=%h drop=0",
                         row_valid, row_idx, row_data, drop_err, row_pat(5'd1));
    end
    row_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit acc, got;
    logic [32:0] d;
    do_reset();
    row_ready = 1'b1; pkt_out_ready = 1'b1;
    pulse_start();
    send_pkt(4'd5, 4'd1, row_pat(5'd0), acc);
    for (int r = 1; r < 7; r++) begin
      wait_req(got, d);
      n_checks++;
      if (got !== 1'b1 || d !== req_pkt(4'd5, 5'(r))) begin
        n_fail++; $display("FAIL mid_req_%0d: got %h want %h", r, d, req_pkt(4'd5, 5'(r)));
      end
      if (r == 6) row_ready = 1'b0;
      send_pkt(4'd5, 4'd1, row_pat(5'(r)), acc);
    end
    wait_req(got, d);
    n_checks++; if (d !== req_pkt(4'd5, 5'd7)) begin n_fail++; $display("FAIL mid_req_7: got %h want %h", d, req_pkt(4'd5, 5'd7)); end
    @(negedge clk);
    n_checks++;
    if (pkt_in_ready !== 1'b1 || row_valid !== 1'b1 || row_idx !== 5'd6) begin
      n_fail++; $display("FAIL mid_pre_reset: got rdy=%b v=%b idx=%0d want rdy=1 v=1 idx=6", pkt_in_ready, row_valid, row_idx);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({pkt_in_ready, pkt_out_valid, row_valid, row_last, done, drop_err} !== 6'b0 ||
        pkt_out_data !== 33'd0 || row_data !== 25'd0 || row_idx !== 5'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got ctrl=%b od=%h rd=%h idx=%0d want all 0",
                         {pkt_in_ready, pkt_out_valid, row_valid, row_last, done, drop_err}, pkt_out_data, row_data, row_idx);
    end
    reset = 1'b0;
    row_ready = 1'b1;
    pkt_in_valid = 1'b1; pkt_in_data = {4'd5, 4'd1, row_pat(5'd7)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (pkt_in_ready !== 1'b0 || row_valid !== 1'b0) begin
        n_fail++; $display("FAIL stale_reply_%0d: got rdy=%b v=%b want 0 0", i, pkt_in_ready, row_valid);
      end
    end
    pkt_in_valid = 1'b0;
    run_timestep();
  endtask

  task automatic test_pe9_backpressure();
    bit got;
    logic [32:0] d;
    s9_row_ready = 1'b0; s9_out_ready = 1'b1;
    @(negedge clk); s9_start = 1'b1;
    @(negedge clk); s9_start = 1'b0;
    s9_in_valid = 1'b1; s9_in_data = {4'd9, 4'd1, row_pat(5'd4)};
    @(negedge clk);
    s9_in_valid = 1'b0;
    n_checks++;
    if (s9_row_valid !== 1'b1 || s9_row_idx !== 5'd4 || s9_row_data !== row_pat(5'd4)) begin
      n_fail++; $display("FAIL pe9_first_row: got v=%b idx=%0d want v=1 idx=4", s9_row_valid, s9_row_idx);
    end
    got = 1'b0; d = '0;
    for (int i = 0; i < 10; i++) begin
      if (s9_out_valid) begin got = 1'b1; d = s9_out_data; break; end
      @(negedge clk);
    end
    n_checks++;
    if (got !== 1'b1 || d !== req_pkt(4'd9, 5'd5)) begin
      n_fail++; $display("FAIL pe9_req_5: got %h want %h", d, req_pkt(4'd9, 5'd5));
    end
    @(negedge clk);
    s9_in_valid = 1'b1; s9_in_data = {4'd9, 4'd1, row_pat(5'd5)};
    @(negedge clk);
    s9_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (s9_out_valid !== 1'b0 || s9_row_idx !== 5'd4) begin
        n_fail++; $display("FAIL pe9_full_hold_%0d: got v=%b idx=%0d want v=0 idx=4", i, s9_out_valid, s9_row_idx);
      end
      @(negedge clk);
    end
    s9_row_ready = 1'b1;
    @(negedge clk);
    s9_row_ready = 1'b0;
    n_checks++;
    if (s9_row_valid !== 1'b1 || s9_row_idx !== 5'd5 || s9_row_data !== row_pat(5'd5)) begin
      n_fail++; $display("FAIL pe9_second_row: got v=%b idx=%0d want v=1 idx=5", s9_row_valid, s9_row_idx);
    end
    got = 1'b0; d = '0;
    for (int i = 0; i < 10; i++) begin
      if (s9_out_valid) begin got = 1'b1; d = s9_out_data; break; end
      @(negedge clk);
    end
    n_checks++;
    if (got !== 1'b1 || d !== req_pkt(4'd9, 5'd6)) begin
      n_fail++; $display("FAIL pe9_req_6: got %h want %h", d, req_pkt(4'd9, 5'd6));
    end
    @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    run_timestep();
    test_two_timesteps();
    do_reset();
    test_req_stall();
    test_bad_packets();
    test_reset_mid();
    do_reset();
    test_pe9_backpressure();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
